// File: rtl/bbpd_voter.sv
// Bang-bang phase detector vote accumulator: majority-votes Alexander early/late
// decisions over WIN UIs and emits one-cycle up/dn corrections plus an idle flag.
module bbpd_voter #(
  parameter int WIN      = 8,
  parameter int THRESH   = 0,
  parameter int IDLE_WIN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic data_in,
  input  logic edge_in,
  output logic up,
  output logic dn,
  output logic idle
);

  localparam int AW = $clog2(WIN) + 2;
  localparam int CW = $clog2(WIN);
  localparam int IW = $clog2(IDLE_WIN + 1);
  localparam logic signed [AW-1:0] TH_P = AW'(THRESH);
  localparam logic signed [AW-1:0] TH_N = AW'(-THRESH);
  localparam logic [CW-1:0]        LAST = CW'(WIN - 1);
  localparam logic [IW-1:0]        IMAX = IW'(IDLE_WIN);

  logic                 d_q;
  logic                 prime;
  logic                 tr;
  logic [CW-1:0]        wcnt;
  logic signed [AW-1:0] acc;
  logic [IW-1:0]        icnt;

  logic                 trans;
  logic                 closing;
  logic                 quiet;
  logic signed [AW-1:0] vote;
  logic signed [AW-1:0] net;
  logic [IW-1:0]        icnt_nxt;

  // Until prime is set the previous bit is stale, so the vote is discarded.
  always_comb begin
    trans    = prime && (d_q != data_in);
    vote     = '0;
    if (trans) vote = (edge_in == data_in) ? AW'(1) : '1;
    net      = acc + vote;
    closing  = en && (wcnt == LAST);
    quiet    = !(tr || trans);
    icnt_nxt = '0;
    if (quiet) icnt_nxt = (icnt == IMAX) ? icnt : icnt + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      prime <= 1'b0;
      wcnt  <= '0;
      acc   <= '0;
      tr    <= 1'b0;
      icnt  <= '0;
      up    <= 1'b0;
      dn    <= 1'b0;
      idle  <= 1'b0;
    end else begin
      d_q <= data_in;
      up  <= 1'b0;
      dn  <= 1'b0;
      if (!en) begin
        // A close coinciding with en low is dropped; idle history survives.
        wcnt  <= '0;
        acc   <= '0;
        tr    <= 1'b0;
        prime <= 1'b0;
      end else begin
        prime <= 1'b1;
        if (closing) begin
          wcnt <= '0;
          acc  <= '0;
          tr   <= 1'b0;
          up   <= (net > TH_P);
          dn   <= (net < TH_N);
          icnt <= icnt_nxt;
          idle <= (icnt_nxt == IMAX);
        end else begin
          wcnt <= wcnt + CW'(1);
          acc  <= net;
          tr   <= tr | trans;
        end
      end
    end
  end

endmodule

// File: tb/tb_bbpd_voter.sv
// Self-checking bench for bbpd_voter: two instances (THRESH=0 and THRESH=2)
// share stimulus; a per-UI reference model feeds an expected queue.
module tb_bbpd_voter;

  logic clk;
  logic rst_n;
  logic en;
  logic data_in;
  logic edge_in;
  logic up0, dn0, idle0;
  logic up2, dn2, idle2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];

  // Reference model state
  bit m_prev, m_primed, m_trans;
  int m_cnt, m_sum, m_icnt;
  bit m_up0, m_dn0, m_up2, m_dn2, m_idle;

  typedef struct {
    int   n_late;
    int   n_early;
    logic up0;
    logic dn0;
    logic up2;
    logic dn2;
  } win_vec_t;

  win_vec_t tbl[10];

  bbpd_voter #(.WIN(8), .THRESH(0), .IDLE_WIN(4)) u_t0 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .edge_in(edge_in),
    .up(up0), .dn(dn0), .idle(idle0)
  );

  bbpd_voter #(.WIN(8), .THRESH(2), .IDLE_WIN(4)) u_t2 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .edge_in(edge_in),
    .up(up2), .dn(dn2), .idle(idle2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_primed = 0; m_trans = 0;
    m_cnt = 0; m_sum = 0; m_icnt = 0;
    m_up0 = 0; m_dn0 = 0; m_up2 = 0; m_dn2 = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic e, input logic d, input logic t);
    bit trn;
    int v;
    int net;
    trn = e && m_primed && (d != m_prev);
    v = trn ? ((t == d) ? 1 : -1) : 0;
    m_up0 = 0; m_dn0 = 0; m_up2 = 0; m_dn2 = 0;
    if (!e) begin
      m_primed = 0; m_cnt = 0; m_sum = 0; m_trans = 0;
    end else begin
      net = m_sum + v;
      if (m_cnt == 7) begin
        m_up0 = (net > 0);  m_dn0 = (net < 0);
        m_up2 = (net > 2);  m_dn2 = (net < -2);
        if (m_trans || trn) m_icnt = 0;
        else if (m_icnt < 4) m_icnt = m_icnt + 1;
        m_idle = (m_icnt == 4);
        m_cnt = 0; m_sum = 0; m_trans = 0;
      end else begin
        m_cnt++;
        m_sum = net;
        m_trans = m_trans || trn;
      end
      m_primed = 1;
    end
    m_prev = d;
    exp_q.push_back({m_up0, m_dn0, m_up2, m_dn2, m_idle, m_idle});
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic ui(input logic e, input logic d, input logic t);
    logic [5:0] exp;
    en = e; data_in = d; edge_in = t;
    model_step(e, d, t);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: expected queue empty");
    end else begin
      exp = exp_q.pop_front();
      check("cycle", {up0, dn0, up2, dn2, idle0, idle2}, exp);
    end
    @(negedge clk);
  endtask

  task automatic late_ui();
    logic d;
    d = ~m_prev;
    ui(1'b1, d, d);
  endtask

  task automatic early_ui();
    logic d;
    d = ~m_prev;
    ui(1'b1, d, m_prev);
  endtask

  task automatic none_ui();
    logic t;
    t = 1'($urandom_range(0, 1));
    ui(1'b1, m_prev, t);
  endtask

  initial begin
    tbl[0] = '{8, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{0, 8, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{4, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{5, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{6, 2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{3, 5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{2, 6, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{4, 1, 1'b1, 1'b0, 1'b1, 1'b0};

    model_reset();
    rst_n = 1'b0; en = 1'b0; data_in = 1'b0; edge_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {up0, dn0, up2, dn2, idle0, idle2}, 6'b0);
    rst_n = 1'b1;

    // Late every UI: first window +7, then +8
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) late_ui();
      check("late_up_pulse", {up0, dn0}, 6'b10);
    end
    late_ui();
    check("late_up_one_cycle", {up0, dn0}, 6'b00);
    for (int i = 0; i < 7; i++) late_ui();
    // Early every UI
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) early_ui();
      check("early_dn_pulse", {up0, dn0, up2, dn2}, 6'b0101);
    end

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < tbl[k].n_late; i++) late_ui();
      for (int i = 0; i < tbl[k].n_early; i++) early_ui();
      for (int i = tbl[k].n_late + tbl[k].n_early; i < 8; i++) none_ui();
      check($sformatf("table_%0d", k), {up0, dn0, up2, dn2},
            {2'b00, tbl[k].up0, tbl[k].dn0, tbl[k].up2, tbl[k].dn2});
    end

    for (int i = 0; i < 4; i++) begin
      late_ui();
      early_ui();
    end
    check("alternating_net_zero", {up0, dn0, up2, dn2}, 6'b0);

    // en dropped at wcnt=5, then a fresh primed window
    for (int i = 0; i < 5; i++) late_ui();
    for (int i = 0; i < 3; i++) ui(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("en_drop_no_pulse", {up0, dn0}, 6'b0);
    for (int i = 0; i < 7; i++) late_ui();
    check("restart_no_early_close", {up0, dn0}, 6'b0);
    late_ui();
    check("restart_full_window_up", {up0, dn0}, 6'b10);

    // en falling on the closing cycle discards that close
    for (int i = 0; i < 7; i++) late_ui();
    ui(1'b0, ~m_prev, ~m_prev);
    check("close_discarded_en_low", {up0, dn0, up2, dn2}, 6'b0);

    // Idle detection
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) none_ui();
      if (w == 2) check("idle_after_3", {5'b0, idle0}, 6'b0);
    end
    check("idle_after_4", {idle0, idle2}, 6'b11);
    late_ui();
    for (int i = 0; i < 7; i++) none_ui();
    check("idle_cleared", {up0, up2, idle0}, 6'b100);
    for (int w = 0; w < 4; w++) for (int i = 0; i < 8; i++) none_ui();
    check("idle_again", {idle0, idle2}, 6'b11);

    // Asynchronous reset at wcnt=7 with a positive accumulator
    for (int i = 0; i < 7; i++) late_ui();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clears", {up0, dn0, up2, dn2, idle0, idle2}, 6'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      late_ui();
      if (up0 !== 1'b0) check("post_reset_no_pulse", {5'b0, up0}, 6'b0);
    end
    late_ui();
    check("post_reset_first_up", {up0, dn0, idle0}, 6'b100);

    check("scoreboard_drained", 6'(exp_q.size()), 6'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
